// File: rtl/pipelined_chunk_adder_if.sv
// Handshake and operand/result bundle for pipelined_chunk_adder.
// The master side supplies operands and accepts results; the slave side is the adder.
interface pipelined_chunk_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             flag_v;
  logic             flag_n;
  logic             flag_z;

  modport master (
    output in_valid, a, b, sub, sat, out_ready,
    input  in_ready, out_valid, sum, cout, flag_v, flag_n, flag_z
  );

  modport slave (
    input  in_valid, a, b, sub, sat, out_ready,
    output in_ready, out_valid, sum, cout, flag_v, flag_n, flag_z
  );
endinterface

// File: rtl/pipelined_chunk_adder.sv
// Pipelined WIDTH-bit add/subtract built from CHUNK-bit ripple slices, one slice per stage.
// The carry is registered between stages; the last stage also applies signed saturation and
// computes the N/Z/V flags. The whole pipe advances together under a valid/ready handshake.
module pipelined_chunk_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input logic                   clk,
  input logic                   rst,
  pipelined_chunk_adder_if.slave bus
);

  // Divisor guarded so a bad CHUNK reaches the check below instead of a divide-by-zero.
  localparam int unsigned ChunkSafe = (CHUNK == 0) ? 1 : CHUNK;
  localparam int unsigned Stages    = WIDTH / ChunkSafe;

  if ((CHUNK < 1) || ((WIDTH % ChunkSafe) != 0)) begin : gen_bad_params
    $error("pipelined_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  // One pipeline slot. b already holds b' (inverted for subtract); sum accumulates the
  // completed low chunks; v/n/z are only meaningful in the final slot.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry;
    logic             sub;
    logic             sat;
    logic             v;
    logic             n;
    logic             z;
  } stage_t;

  stage_t stage_q [Stages];
  stage_t stage_d [Stages];
  logic   adv;

  // Bubbles are not collapsed: the pipe moves only when the output slot is free or consumed.
  assign adv = !stage_q[Stages-1].valid | bus.out_ready;

  // Next state of every slot: add one chunk per stage, finish flags/saturation at the end.
  always_comb begin
    stage_t          src;
    stage_t          nxt;
    logic [CHUNK:0]  part;
    int unsigned     prev;
    for (int unsigned k = 0; k < Stages; k++) begin
      prev = (k == 0) ? 0 : k - 1;
      if (k == 0) begin
        src       = '0;
        src.valid = bus.in_valid & adv;
        src.a     = bus.a;
        src.b     = bus.sub ? ~bus.b : bus.b;
        src.carry = bus.sub;
        src.sub   = bus.sub;
        src.sat   = bus.sat;
      end else begin
        src = stage_q[prev];
      end
      nxt  = src;
      part = {1'b0, src.a[k*CHUNK +: CHUNK]} + {1'b0, src.b[k*CHUNK +: CHUNK]}
           + {{CHUNK{1'b0}}, src.carry};
      nxt.sum[k*CHUNK +: CHUNK] = part[CHUNK-1:0];
      nxt.carry                 = part[CHUNK];
      if (k == Stages - 1) begin
        // V and C describe the raw result; N and Z describe what is actually delivered.
        nxt.v = (src.a[WIDTH-1] == src.b[WIDTH-1]) & (nxt.sum[WIDTH-1] != src.a[WIDTH-1]);
        if (src.sat && nxt.v) begin
          nxt.sum = src.a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
        nxt.n = nxt.sum[WIDTH-1];
        nxt.z = (nxt.sum == '0);
      end
      stage_d[k] = adv ? nxt : stage_q[k];
    end
  end

  // Slot registers; reset empties every slot and zeroes the visible result.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < Stages; k++) begin
      if (rst) begin
        stage_q[k] <= '0;
      end else begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = stage_q[Stages-1].valid;
  assign bus.sum       = stage_q[Stages-1].sum;
  assign bus.cout      = stage_q[Stages-1].carry;
  assign bus.flag_v    = stage_q[Stages-1].v;
  assign bus.flag_n    = stage_q[Stages-1].n;
  assign bus.flag_z    = stage_q[Stages-1].z;

endmodule
